// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with input synchronizer, mid-bit sampling and one-deep output buffer
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       ready,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int         HALF      = CLKS_PER_BIT / 2;
    localparam logic [7:0] BIT_LAST  = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF_LAST = 8'((HALF > 0) ? (HALF - 1) : 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic [7:0]             cnt;
    logic [3:0]             bit_idx;
    logic [7:0]             shift;

    // Sync flops reset high so a released reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync[0] <= rx;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
        end
    end

    assign rx_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            bit_idx   <= 4'd0;
            shift     <= 8'd0;
            data_out  <= 8'd0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt     <= 8'd0;
                    bit_idx <= 4'd0;
                    if (!rx_s) begin
                        busy  <= 1'b1;
                        // With HALF=0 the start sample coincides with detection.
                        state <= (HALF == 0) ? DATA : START;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= 8'd0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt                 <= 8'd0;
                        shift[bit_idx[2:0]] <= rx_s;
                        if (bit_idx == 4'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= 8'd0;
                        bit_idx <= 4'd0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            // A byte consumed this same cycle frees the buffer for the new one.
                            if (!valid || ready) begin
                                data_out <= shift;
                                valid    <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx with a timestamp-based reference model
module tb_uart_rx;

    localparam int CPB_OF  [2] = '{16, 1};
    localparam int SYNC_OF [2] = '{2, 1};
    localparam int M_IDLE = 0;
    localparam int M_ACT  = 1;
    localparam int M_WAIT = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      rx_in = 2'b11;
    logic [1:0]      rdy = 2'b00;
    logic [1:0][7:0] dout;
    logic [1:0]      vld;
    logic [1:0]      bsy;
    logic [1:0]      ferr;
    logic [1:0]      ovr;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_in[0]), .ready(rdy[0]),
        .data_out(dout[0]), .valid(vld[0]), .busy(bsy[0]),
        .frame_err(ferr[0]), .overrun(ovr[0])
    );

    uart_rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(1)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_in[1]), .ready(rdy[1]),
        .data_out(dout[1]), .valid(vld[1]), .busy(bsy[1]),
        .frame_err(ferr[1]), .overrun(ovr[1])
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: frame events located by arithmetic on the start timestamp.
    int         cyc = 0;
    int         m_mode [2];
    int         m_t0   [2];
    logic [7:0] m_byte [2];
    logic [4:0] hist   [2];
    logic [7:0] e_data [2];
    logic       e_valid[2];
    logic       e_busy [2];
    logic       e_ferr [2];
    logic       e_ovr  [2];

    task automatic model_step(input int n);
        int   c, h, d, k;
        logic rs, was_valid;
        c = CPB_OF[n];
        h = c / 2;
        hist[n] = {hist[n][3:0], rx_in[n]};
        rs = hist[n][SYNC_OF[n]];
        was_valid = e_valid[n];
        e_ferr[n] = 1'b0;
        e_ovr[n]  = 1'b0;
        if (was_valid && rdy[n]) e_valid[n] = 1'b0;
        if (m_mode[n] == M_IDLE && !rs) begin
            m_mode[n] = M_ACT;
            m_t0[n]   = cyc;
        end else if (m_mode[n] == M_WAIT && rs) begin
            m_mode[n] = M_IDLE;
        end
        if (m_mode[n] == M_ACT) begin
            d = cyc - m_t0[n];
            if (d == h) begin
                if (rs) m_mode[n] = M_IDLE;
            end else if (d > h && (d - h) % c == 0) begin
                k = (d - h) / c;
                if (k <= 8) begin
                    m_byte[n][k-1] = rs;
                end else if (!rs) begin
                    e_ferr[n] = 1'b1;
                    m_mode[n] = M_WAIT;
                end else begin
                    if (!was_valid || rdy[n]) begin
                        e_data[n]  = m_byte[n];
                        e_valid[n] = 1'b1;
                    end else begin
                        e_ovr[n] = 1'b1;
                    end
                    m_mode[n] = M_IDLE;
                end
            end
        end
        e_busy[n] = (m_mode[n] != M_IDLE);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                m_mode[n]  = M_IDLE;
                m_t0[n]    = 0;
                m_byte[n]  = 8'h00;
                hist[n]    = 5'b11111;
                e_data[n]  = 8'h00;
                e_valid[n] = 1'b0;
                e_busy[n]  = 1'b0;
                e_ferr[n]  = 1'b0;
                e_ovr[n]   = 1'b0;
            end
        end else begin
            cyc++;
            for (int n = 0; n < 2; n++) model_step(n);
        end
    end

    // Compare process plus handshake monitor, sampled on the falling edge.
    logic [7:0] rxq0[$];
    logic [7:0] rxq1[$];
    logic       pv[2];
    logic [7:0] pd[2];
    int         vcnt[2], fcnt[2], ocnt[2], bcnt[2];

    always @(negedge clk) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) pv[n] = 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                chk($sformatf("valid%0d@%0d", n, cyc), vld[n], e_valid[n]);
                chk($sformatf("data%0d@%0d", n, cyc), dout[n], e_data[n]);
                chk($sformatf("busy%0d@%0d", n, cyc), bsy[n], e_busy[n]);
                chk($sformatf("frame_err%0d@%0d", n, cyc), ferr[n], e_ferr[n]);
                chk($sformatf("overrun%0d@%0d", n, cyc), ovr[n], e_ovr[n]);
                if (pv[n] && rdy[n]) begin
                    if (n == 0) rxq0.push_back(pd[n]);
                    else        rxq1.push_back(pd[n]);
                end
                pv[n] = vld[n];
                pd[n] = dout[n];
                vcnt[n] += int'(vld[n]);
                fcnt[n] += int'(ferr[n]);
                ocnt[n] += int'(ovr[n]);
                bcnt[n] += int'(bsy[n]);
            end
        end
    end

    task automatic step(input int k);
        repeat (k) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic clear_stats();
        for (int n = 0; n < 2; n++) begin
            vcnt[n] = 0;
            fcnt[n] = 0;
            ocnt[n] = 0;
            bcnt[n] = 0;
        end
        rxq0.delete();
        rxq1.delete();
    endtask

    task automatic send(input int n, input logic [7:0] b, input logic stop_bit);
        int c;
        c = CPB_OF[n];
        rx_in[n] = 1'b0;
        step(c);
        for (int i = 0; i < 8; i++) begin
            rx_in[n] = b[i];
            step(c);
        end
        rx_in[n] = stop_bit;
        step(c);
    endtask

    int lat;
    bit found;

    initial begin
        clear_stats();
        step(3);
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("rst_data%0d", n), dout[n], 8'h00);
            chk($sformatf("rst_valid%0d", n), vld[n], 1'b0);
            chk($sformatf("rst_busy%0d", n), bsy[n], 1'b0);
            chk($sformatf("rst_ferr%0d", n), ferr[n], 1'b0);
            chk($sformatf("rst_ovr%0d", n), ovr[n], 1'b0);
        end
        rst = 1'b0;
        step(5);

        // 0xA5 with ready high: latency 2+8+144+1 and a single valid cycle
        rdy[0] = 1'b1;
        clear_stats();
        lat = 0;
        found = 0;
        fork
            send(0, 8'hA5, 1'b1);
            begin
                while (!found && lat < 400) begin
                    @(negedge clk);
                    lat++;
                    if (vld[0]) found = 1;
                end
            end
        join
        chk("latency_a5", lat, 155);
        step(20);
        chk("a5_count", rxq0.size(), 1);
        if (rxq0.size() > 0) chk("a5_byte", rxq0[0], 8'hA5);
        chk("a5_valid_cycles", vcnt[0], 1);

        // Start glitch: busy for HALF cycles, nothing else
        clear_stats();
        rx_in[0] = 1'b0;
        step(4);
        rx_in[0] = 1'b1;
        step(30);
        chk("glitch_busy_cycles", bcnt[0], 8);
        chk("glitch_valid", vcnt[0], 0);
        chk("glitch_ferr", fcnt[0], 0);
        chk("glitch_ovr", ocnt[0], 0);

        // Framing error, line held low afterwards
        clear_stats();
        send(0, 8'h3C, 1'b0);
        step(40);
        chk("ferr_pulses", fcnt[0], 1);
        chk("ferr_busy_held", bsy[0], 1'b1);
        rx_in[0] = 1'b1;
        step(10);
        chk("ferr_idle_after", bsy[0], 1'b0);
        chk("ferr_pulses_end", fcnt[0], 1);
        chk("ferr_valid", vcnt[0], 0);

        // Overrun with ready low
        rdy[0] = 1'b0;
        clear_stats();
        send(0, 8'h11, 1'b1);
        step(4);
        send(0, 8'h22, 1'b1);
        step(20);
        chk("ovr_data", dout[0], 8'h11);
        chk("ovr_valid", vld[0], 1'b1);
        chk("ovr_pulses", ocnt[0], 1);
        rdy[0] = 1'b1;
        step(1);
        chk("ovr_valid_drop", vld[0], 1'b0);
        chk("ovr_consumed", rxq0.size(), 1);
        if (rxq0.size() > 0) chk("ovr_consumed_byte", rxq0[0], 8'h11);

        // One clock per bit, one idle cycle between frames
        rdy[1] = 1'b1;
        clear_stats();
        send(1, 8'h81, 1'b1);
        step(1);
        send(1, 8'h7E, 1'b1);
        step(20);
        chk("cpb1_count", rxq1.size(), 2);
        if (rxq1.size() > 1) begin
            chk("cpb1_first", rxq1[0], 8'h81);
            chk("cpb1_second", rxq1[1], 8'h7E);
        end
        chk("cpb1_ferr", fcnt[1], 0);
        chk("cpb1_ovr", ocnt[1], 0);

        // Reset during bit 3 of 0xFF, then 0x5A
        rdy[0] = 1'b1;
        clear_stats();
        rx_in[0] = 1'b0;
        step(16);
        rx_in[0] = 1'b1;
        step(56);
        rst = 1'b1;
        #1;
        chk("midrst_busy", bsy[0], 1'b0);
        chk("midrst_valid", vld[0], 1'b0);
        step(2);
        rst = 1'b0;
        step(100);
        send(0, 8'h5A, 1'b1);
        step(20);
        chk("midrst_count", rxq0.size(), 1);
        if (rxq0.size() > 0) chk("midrst_byte", rxq0[0], 8'h5A);
        chk("midrst_ferr", fcnt[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
